// File: rtl/jogo_memoria_uc.sv
// jogo_memoria_uc -- control unit (Moore FSM) for a 16-round memory/sequence game.
//
// The datapath keeps the stored sequence, a move-address counter (E), a
// sequence-length counter (S) and a register holding the last move (R). This
// unit sequences those resources and reports the outcome of the game.
//
// Parameters
//   TIMEOUT_CYCLES  clock cycles allowed per move (5000 = 5 s at 1 kHz)
//   TW              width of the timeout counter, 2**TW >= TIMEOUT_CYCLES
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   jogar       in   start / restart request (level)
//   tem_jogada  in   one-cycle pulse: a button was pressed
//   igual       in   registered move matches the memory word
//   fimE        in   move address reached the current sequence length
//   fimS        in   current sequence length is the last one (16th)
//   zeraE/contaE, zeraS/contaS, zeraR/registraR   out  datapath controls
//   pronto, ganhou, perdeu, timeout               out  game status
//   db_estado   out  current state code (debug)
//
// Build option
//   JOGO_UC_TIMEOUT_EN  when defined, a per-move timeout counter and the
//                       fim_timeout end state are built; otherwise the unit
//                       waits indefinitely for each move and timeout stays 0.

module jogo_memoria_uc #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW             = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimS,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraS,
  output logic       contaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [3:0] db_estado
);

  // Reject a counter too narrow to reach the last timeout count.
  if ((TIMEOUT_CYCLES < 1) || ((64'd1 << TW) < 64'(TIMEOUT_CYCLES))) begin : g_bad_cfg
    $error("jogo_memoria_uc: TW too small for TIMEOUT_CYCLES");
  end

  typedef enum logic [3:0] {
    inicial        = 4'h0,
    preparacao     = 4'h1,
    inicio_rodada  = 4'h2,
    espera_jogada  = 4'h3,
    registra       = 4'h4,
    comparacao     = 4'h5,
    proxima_jogada = 4'h6,
    proxima_rodada = 4'h7,
    fim_ganhou     = 4'hA,
    fim_perdeu     = 4'hB,
    fim_timeout    = 4'hC
  } state_t;

  state_t state;
  state_t next;
  logic   expired;

`ifdef JOGO_UC_TIMEOUT_EN
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  assign expired = (cnt == T_LAST);

  // Counts only while waiting for a move; saturates at the last count and is
  // held at zero in every other state, so each wait starts from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == espera_jogada) begin
      if (!expired) cnt <= cnt + TW'(1);
    end else begin
      cnt <= '0;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= inicial;
    else        state <= next;
  end

  always_comb begin
    next = inicial;
    case (state)
      inicial:        next = jogar ? preparacao : inicial;
      preparacao:     next = inicio_rodada;
      inicio_rodada:  next = espera_jogada;
      // A press in the expiry cycle still counts as a valid move.
      espera_jogada:  if (tem_jogada)   next = registra;
                      else if (expired) next = fim_timeout;
                      else              next = espera_jogada;
      registra:       next = comparacao;
      comparacao:     if (!igual)     next = fim_perdeu;
                      else if (!fimE) next = proxima_jogada;
                      else if (fimS)  next = fim_ganhou;
                      else            next = proxima_rodada;
      proxima_jogada: next = espera_jogada;
      proxima_rodada: next = inicio_rodada;
      fim_ganhou:     next = jogar ? preparacao : fim_ganhou;
      fim_perdeu:     next = jogar ? preparacao : fim_perdeu;
`ifdef JOGO_UC_TIMEOUT_EN
      fim_timeout:    next = jogar ? preparacao : fim_timeout;
`endif
      default:        next = inicial;
    endcase
  end

  // Outputs decode the current state only.
  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraS     = 1'b0;
    contaS    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    ganhou    = 1'b0;
    perdeu    = 1'b0;
    timeout   = 1'b0;
    case (state)
      preparacao:     begin zeraE = 1'b1; zeraS = 1'b1; zeraR = 1'b1; end
      inicio_rodada:  zeraE = 1'b1;
      registra:       registraR = 1'b1;
      proxima_jogada: contaE = 1'b1;
      proxima_rodada: contaS = 1'b1;
      fim_ganhou:     begin pronto = 1'b1; ganhou = 1'b1; end
      fim_perdeu:     begin pronto = 1'b1; perdeu = 1'b1; end
`ifdef JOGO_UC_TIMEOUT_EN
      fim_timeout:    begin pronto = 1'b1; timeout = 1'b1; end
`endif
      default:        ;
    endcase
  end

  assign db_estado = state;

endmodule

// File: tb/tb_jogo_memoria_uc.sv
// Directed testbench for jogo_memoria_uc: start-up, full win, loss and
// restart, asynchronous mid-game reset, and the per-move timeout (or its
// absence when JOGO_UC_TIMEOUT_EN is undefined).

module tb_jogo_memoria_uc;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic       tem_jogada = 1'b0;
  logic       igual = 1'b0;
  logic       fimE = 1'b0;
  logic       fimS = 1'b0;
  logic       zeraE, contaE, zeraS, contaS, zeraR, registraR;
  logic       pronto, ganhou, perdeu, timeout;
  logic [3:0] db_estado;
  logic [9:0] outs;

  int total = 0;
  int passed = 0;
  int n_reg = 0;
  int n_contaS = 0;
  int base_reg, base_s;

  // Expected output vectors {zeraE,contaE,zeraS,contaS,zeraR,registraR,pronto,ganhou,perdeu,timeout}
  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_PREP = 10'b1010100000;
  localparam logic [9:0] O_INIR = 10'b1000000000;
  localparam logic [9:0] O_REG  = 10'b0000010000;
  localparam logic [9:0] O_PJOG = 10'b0100000000;
  localparam logic [9:0] O_PROD = 10'b0001000000;
  localparam logic [9:0] O_WIN  = 10'b0000001100;
  localparam logic [9:0] O_LOSE = 10'b0000001010;
  localparam logic [9:0] O_TOUT = 10'b0000001001;

  jogo_memoria_uc #(.TIMEOUT_CYCLES(5000), .TW(13)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .tem_jogada(tem_jogada),
    .igual(igual), .fimE(fimE), .fimS(fimS),
    .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
    .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .db_estado(db_estado)
  );

  assign outs = {zeraE, contaE, zeraS, contaS, zeraR, registraR, pronto, ganhou, perdeu, timeout};

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (registraR) n_reg++;
    if (contaS)    n_contaS++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_st(input string tag, input logic [3:0] st, input logic [9:0] o);
    check(tag, {18'd0, db_estado, outs}, {18'd0, st, o});
  endtask

  // One button press in espera_jogada, ending after the comparacao decision.
  task automatic move(input logic i, input logic e, input logic s);
    tem_jogada = 1'b1;
    step();
    tem_jogada = 1'b0;
    igual = i; fimE = e; fimS = s;
    step();
    step();
    igual = 1'b0; fimE = 1'b0; fimS = 1'b0;
  endtask

  // Round r has r correct moves; returns in espera_jogada unless the game is won.
  task automatic play_round(input int r);
    for (int m = 1; m <= r; m++) begin
      move(1'b1, m == r, r == 16);
      if (m < r) begin
        check_st("after_move", 4'h6, O_PJOG);
        step();
      end else if (r < 16) begin
        check_st("end_round", 4'h7, O_PROD);
        step();
        step();
      end
    end
  endtask

  task automatic start_game();
    jogar = 1'b1;
    step();
    check_st("restart_prep", 4'h1, O_PREP);
    jogar = 1'b0;
    step();
    step();
    check_st("restart_wait", 4'h3, O_NONE);
  endtask

  initial begin
    // reset held
    repeat (3) @(posedge clock);
    #1;
    check_st("in_reset", 4'h0, O_NONE);
    @(negedge clock);
    reset = 1'b1;
    step();
    check_st("after_release", 4'h0, O_NONE);
    step();
    check_st("idle", 4'h0, O_NONE);

    // start-up: jogar held for 5 cycles
    jogar = 1'b1;
    step();
    check_st("prep", 4'h1, O_PREP);
    step();
    check_st("inicio_rodada", 4'h2, O_INIR);
    step();
    check_st("espera", 4'h3, O_NONE);
    step();
    check_st("jogar_ignored1", 4'h3, O_NONE);
    step();
    check_st("jogar_ignored2", 4'h3, O_NONE);
    jogar = 1'b0;

    // full win
    base_reg = n_reg;
    base_s   = n_contaS;
    for (int r = 1; r <= 16; r++) play_round(r);
    check_st("win_state", 4'hA, O_WIN);
    check("registraR_pulses", 32'(n_reg - base_reg), 32'd136);
    check("contaS_pulses", 32'(n_contaS - base_s), 32'd15);
    tem_jogada = 1'b1;
    step();
    tem_jogada = 1'b0;
    check_st("win_held", 4'hA, O_WIN);

    // loss at round 3, move 2, then restart
    start_game();
    play_round(1);
    play_round(2);
    move(1'b1, 1'b0, 1'b0);
    check_st("r3_move1", 4'h6, O_PJOG);
    step();
    move(1'b0, 1'b0, 1'b0);
    check_st("lose_state", 4'hB, O_LOSE);
    step();
    check_st("lose_held", 4'hB, O_LOSE);
    jogar = 1'b1;
    step();
    check_st("restart_after_loss", 4'h1, O_PREP);
    jogar = 1'b0;

    // asynchronous reset mid-cycle, round 4
    step();
    step();
    play_round(1);
    play_round(2);
    play_round(3);
    check_st("round4_wait", 4'h3, O_NONE);
    #2;
    reset = 1'b0;
    #1;
    check_st("async_reset", 4'h0, O_NONE);
    #1;
    reset = 1'b1;
    step();
    check_st("post_reset1", 4'h0, O_NONE);
    step();
    check_st("post_reset2", 4'h0, O_NONE);

    // per-move timeout
    start_game();
`ifdef JOGO_UC_TIMEOUT_EN
    repeat (4999) step();
    check_st("before_timeout", 4'h3, O_NONE);
    step();
    check_st("timeout_state", 4'hC, O_TOUT);
    tem_jogada = 1'b1;
    step();
    tem_jogada = 1'b0;
    check_st("timeout_held", 4'hC, O_TOUT);
    start_game();
    repeat (4999) step();
    tem_jogada = 1'b1;
    step();
    tem_jogada = 1'b0;
    check_st("press_at_expiry", 4'h4, O_REG);
`else
    repeat (10000) step();
    check_st("no_timeout", 4'h3, O_NONE);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
